// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame constants and bit-period helper
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  function automatic int bit_period(input int fclk, input int baud);
    return fclk / baud;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-width counter that loads FCLK/BAUD-1, counts down to zero and holds
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int FCLK = 100000000,
  parameter int BAUD = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);
  localparam int P = bit_period(FCLK, BAUD);
  localparam int W = P < 2 ? 1 : $clog2(P);
  if (P < 2) begin : g_bad_period
    $error("uart_baud_cnt: FCLK/BAUD must be at least 2");
  end
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  // reload on reset or request, otherwise count down and park at zero
  always_ff @(posedge clk) cnt <= rst || load ? W'(P - 1) : zero ? cnt : cnt - W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, valid/ready byte in, LSB-first serial out; define UART_TX_PARITY_EN to add an even-parity bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int FCLK = 100000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       idle
);
  uart_tx_state_t state, state_d;
  logic [DATA_BITS-1:0] shift;
  logic [2:0] bit_cnt;
  logic zero, load, accept, last, tx_d;
  assign tx_ready = state == IDLE;
  assign idle = tx_ready;
  assign accept = tx_valid & tx_ready;
  assign last = bit_cnt == 3'(DATA_BITS - 1);
  assign load = tx_ready ? accept : zero;
  uart_baud_cnt #(.FCLK(FCLK), .BAUD(BAUD)) u_baud (.clk(clk), .rst(rst), .load(load), .zero(zero));
`ifdef UART_TX_PARITY_EN
  logic par;
  // even parity of the accepted byte
  always_ff @(posedge clk) par <= rst ? 1'b0 : accept ? ^tx_data : par;
`endif
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  // line flop, shift register and data-bit counter
  always_ff @(posedge clk)
    if (rst) begin
      tx <= 1'b1;
      shift <= '0;
      bit_cnt <= '0;
    end else begin
      tx <= tx_d;
      if (accept) begin
        shift <= tx_data;
        bit_cnt <= '0;
      end else if (state == DATA && zero && !last) begin
        shift <= shift >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  // next state: each non-idle state advances when the bit period expires
  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:    state_d = accept ? START : IDLE;
      START:   state_d = zero ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:    state_d = zero && last ? PARITY : DATA;
      PARITY:  state_d = zero ? STOP : PARITY;
`else
      DATA:    state_d = zero && last ? STOP : DATA;
`endif
      STOP:    state_d = zero ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // next line level, registered so tx comes from a single flop
  always_comb begin
    tx_d = 1'b1;
    case (state)
      IDLE:    tx_d = !accept;
      START:   tx_d = zero ? shift[0] : 1'b0;
`ifdef UART_TX_PARITY_EN
      DATA:    tx_d = !zero ? shift[0] : last ? par : shift[1];
      PARITY:  tx_d = zero | par;
`else
      DATA:    tx_d = !zero ? shift[0] : last | shift[1];
`endif
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at FCLK=1MHz, BAUD=100k (10 cycles per bit)
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int FCLK = 1000000;
  localparam int BAUD = 100000;
  localparam int P = FCLK / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx, idle;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  logic mon_busy = 1'b0;
  logic mon_prev = 1'b1;
  int mon_pos = 0;
  logic [10:0] mon_fr = '1;
  uart_tx #(.FCLK(FCLK), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .idle(idle)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction
  // decode frames off the line, sampling the middle of each bit, and score them
  initial forever begin
    @(negedge clk);
    if (rst) mon_busy = 1'b0;
    else if (mon_busy) mon_pos++;
    else if (mon_prev && !tx) begin
      mon_busy = 1'b1;
      mon_pos = 0;
      mon_fr = '1;
      starts.push_back(cyc);
    end
    if (mon_busy && mon_pos % P == P / 2 - 1) mon_fr[mon_pos / P] = tx;
    if (mon_busy && mon_pos == NB * P - 1) begin
      mon_busy = 1'b0;
      frames++;
      if (exp_q.size() == 0) chk("unexpected_frame", 32'(mon_fr), 32'h0);
      else chk("frame", 32'(mon_fr), 32'(frame_of(exp_q.pop_front())));
    end
    mon_prev = tx;
  end
  // wait for a handshake, returning just after the accepting edge
  task automatic wait_accept();
    int i = 0;
    while (i < 300) begin
      @(negedge clk);
      if (tx_ready && tx_valid) break;
      i++;
    end
    chk("accept_wait", 32'(i < 300), 32'h1);
    @(posedge clk);
    #1;
  endtask
  // count consecutive not-ready cycles starting at the next falling edge
  task automatic ready_low(output int n);
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_ready", 32'(tx_ready), 32'h1);
    chk("rst_idle", 32'(idle), 32'h1);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (!(tx && tx_ready && idle)) n++;
    end
    chk("idle50_bad", n, 0);
    @(posedge clk);
    #1 tx_data = 8'hA5;
    tx_valid = 1'b1;
    wait_accept();
    exp_q.push_back(8'hA5);
    tx_valid = 1'b0;
    tx_data = 8'hFF;
    @(negedge clk);
    chk("latency_tx", 32'(tx), 32'h0);
    n = 1;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      if (!tx_ready) n++;
    end
    chk("ready_low", n, NB * P);
    repeat (5) @(negedge clk);
    starts.delete();
    @(posedge clk);
    #1 tx_data = 8'h00;
    tx_valid = 1'b1;
    wait_accept();
    exp_q.push_back(8'h00);
    tx_data = 8'hFF;
    wait_accept();
    exp_q.push_back(8'hFF);
    tx_valid = 1'b0;
    repeat (NB * P + 5) @(negedge clk);
    chk("pitch", starts.size() == 2 ? starts[1] - starts[0] : -1, NB * P + 1);
    n = frames;
    @(posedge clk);
    #1 tx_data = 8'h5A;
    tx_valid = 1'b1;
    wait_accept();
    exp_q.push_back(8'h5A);
    tx_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (NB * P + 30) @(negedge clk);
    chk("ignored_frames", frames - n, 1);
    @(posedge clk);
    #1 tx_data = 8'hC3;
    tx_valid = 1'b1;
    wait_accept();
    tx_valid = 1'b0;
    repeat (44) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", 32'(tx), 32'h1);
    chk("abort_ready", 32'(tx_ready), 32'h1);
    chk("abort_idle", 32'(idle), 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (!tx) n++;
    end
    chk("abort_low", n, 0);
`ifdef UART_TX_PARITY_EN
    @(posedge clk);
    #1 tx_data = 8'h07;
    tx_valid = 1'b1;
    wait_accept();
    exp_q.push_back(8'h07);
    tx_valid = 1'b0;
    ready_low(n);
    chk("parity_frame_len", n + 1, 110);
    repeat (10) @(negedge clk);
`endif
    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit=20000", cyc);
    $fatal(1);
  end
endmodule
